blake2s_msg_packer: RTL and testbench

Upstream feeder for the BLAKE2s hash core. Takes the host message as a byte stream with a last-byte marker. Slices it into 64-byte blocks, each byte tagged with its index. Zero-pads the final block and raises block_first/block_last so the core knows when to compress. Also tracks the running message length ll that the core needs for the final counter.

---
 rtl/blake2s_msg_packer.sv | 124 ++++++++++++
 tb/tb_blake2s_msg_packer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2s_msg_packer.sv
// Byte-stream front end for the BLAKE2s core: slices a host message into
// 64-byte blocks, zero-pads the final block and tracks the message length.
module blake2s_msg_packer #(
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned LL_W        = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_i,
  input  logic [7:0]                     data_i,
  input  logic                           last_i,
  output logic                           ready_o,
  input  logic                           ready_v_i,
  output logic                           data_v_o,
  output logic [7:0]                     data_o,
  output logic [$clog2(BLOCK_BYTES)-1:0] data_idx_o,
  output logic                           block_first_o,
  output logic                           block_last_o,
  output logic [LL_W-1:0]                ll_o,
  output logic                           busy_o
);

  localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             data_v_d;
  logic [7:0]       data_d;
  logic [IDX_W-1:0] idx_d, idx_next;
  logic             first_d, last_d;
  logic [LL_W-1:0]  ll_d;
  logic             xfer;

  // Host handshake: block starts wait on the core, mid-block bytes never stall.
  always_comb begin
    ready_o = 1'b0;
    case (state_q)
      IDLE:    ready_o = ready_v_i;
      FILL:    ready_o = 1'b1;
      WAIT:    ready_o = ready_v_i;
      default: ready_o = 1'b0;
    endcase
  end

  assign xfer     = valid_i & ready_o;
  assign idx_next = data_idx_o + IDX_W'(1);
  assign busy_o   = (state_q != IDLE);

  // Next-state and next-output logic; output registers hold unless a byte moves.
  always_comb begin
    state_d  = state_q;
    data_v_d = 1'b0;
    data_d   = data_o;
    idx_d    = data_idx_o;
    first_d  = block_first_o;
    last_d   = block_last_o;
    ll_d     = ll_o;
    case (state_q)
      IDLE, WAIT: begin
        if (xfer) begin
          data_v_d = 1'b1;
          data_d   = data_i;
          idx_d    = '0;
          last_d   = last_i;
          first_d  = (state_q == IDLE);
          ll_d     = (state_q == IDLE) ? LL_W'(1) : ll_o + LL_W'(1);
          state_d  = last_i ? PAD : FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          data_v_d = 1'b1;
          data_d   = data_i;
          idx_d    = idx_next;
          last_d   = last_i;
          ll_d     = ll_o + LL_W'(1);
          if (idx_next == IDX_LAST) begin
            state_d = last_i ? IDLE : WAIT;
          end else if (last_i) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        data_v_d = 1'b1;
        data_d   = 8'd0;
        idx_d    = idx_next;
        last_d   = 1'b1;
        if (idx_next == IDX_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      data_v_o      <= 1'b0;
      data_o        <= 8'd0;
      data_idx_o    <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      ll_o          <= '0;
    end else begin
      state_q       <= state_d;
      data_v_o      <= data_v_d;
      data_o        <= data_d;
      data_idx_o    <= idx_d;
      block_first_o <= first_d;
      block_last_o  <= last_d;
      ll_o          <= ll_d;
    end
  end

endmodule

// File: tb/tb_blake2s_msg_packer.sv
// Self-checking bench for blake2s_msg_packer: table vectors, random messages
// against a block-level reference model, and hand-written corner sequences.
module tb_blake2s_msg_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, last_i, ready_v_i;
  logic [7:0]  data_i;
  logic        ready_o, data_v_o, block_first_o, block_last_o, busy_o;
  logic [7:0]  data_o;
  logic [5:0]  data_idx_o;
  logic [63:0] ll_o;

  blake2s_msg_packer dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i),
    .last_i(last_i), .ready_o(ready_o), .ready_v_i(ready_v_i),
    .data_v_o(data_v_o), .data_o(data_o), .data_idx_o(data_idx_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o),
    .ll_o(ll_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_len = 0;
  bit mon_en  = 1'b0;

  logic [7:0]  msg [0:1023];
  logic [15:0] got[$];
  int          gcyc[$];

  typedef struct {
    int          len;
    int          base;     // <0: random bytes, else byte i = base + i
    int          vmode;    // 0 always valid, 1 toggle, 2 random
    int          rvmode;   // 0 core always ready, 2 random
    int          exp_out;  // expected number of bytes toward the core
    int          exp_span; // cycles from idx0 to idx63 of block 0, <0 skip
  } vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every presented byte as {data, idx, first, last}.
  always @(negedge clk) begin
    if (mon_en && data_v_o) begin
      got.push_back({data_o, data_idx_o, block_first_o, block_last_o});
      gcyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive n bytes of msg[]; returns right before the edge that takes the last byte.
  task automatic send(input int n, input int vmode, input int rvmode, input bit stall);
    int p = 0;
    int k = 0;
    int stall_cnt = 0;
    int guard = 0;
    bit v, rv;
    while (p < n) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        chk("send_timeout", 64'(p), 64'(n));
        return;
      end
      v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((k % 2) == 0) : (($urandom % 3) != 0);
      rv = (stall_cnt > 0) ? 1'b0 : (rvmode == 0) ? 1'b1 : (($urandom % 4) != 0);
      valid_i   = v;
      data_i    = msg[p];
      last_i    = (p == n - 1);
      ready_v_i = rv;
      #1;
      if (stall_cnt > 0) begin
        chk("stall_ready", 64'(ready_o), 64'd0);
        if (stall_cnt < 5) chk("stall_no_out", 64'(data_v_o), 64'd0);
        stall_cnt--;
      end
      if (v && ready_o) begin
        p++;
        if (stall && p == 64) stall_cnt = 5;
      end
      k++;
    end
  endtask

  task automatic wait_done();
    int g = 0;
    @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_v_i = 1'b1;
    while (busy_o && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("idle_after_msg", 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Reference: whole blocks of the message, zero-filled, flags from block position.
  task automatic check_msg(input string tag, input int n, input int exp_span);
    logic [15:0] exp[$];
    int nblk = (n + 63) / 64;
    int tail = (n - 1) % 64;
    int nbad = 0;
    logic [7:0] d;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) begin
        d = (b * 64 + i < n) ? msg[b * 64 + i] : 8'h00;
        exp.push_back({d, 6'(i), (b == 0), ((b == nblk - 1) && (i >= tail))});
      end
    end
    chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int j = 0; j < exp.size(); j++) begin
      if (j >= got.size() || got[j] !== exp[j]) nbad++;
    end
    chk({tag, "_stream"}, 64'(nbad), 64'd0);
    chk({tag, "_ll"}, ll_o, 64'(n));
    if (exp_span >= 0 && gcyc.size() >= 64)
      chk({tag, "_span"}, 64'(gcyc[63] - gcyc[0]), 64'(exp_span));
    got.delete();
    gcyc.delete();
    last_len = n;
  endtask

  initial begin
    vec_t vecs[7];
    int n;
    vecs[0] = '{len: 3,   base: 'h61, vmode: 0, rvmode: 0, exp_out: 64,  exp_span: 63};
    vecs[1] = '{len: 64,  base: 0,    vmode: 0, rvmode: 0, exp_out: 64,  exp_span: 63};
    vecs[2] = '{len: 10,  base: 'h20, vmode: 1, rvmode: 0, exp_out: 64,  exp_span: 72};
    vecs[3] = '{len: 1,   base: 'hA5, vmode: 0, rvmode: 0, exp_out: 64,  exp_span: 63};
    vecs[4] = '{len: 128, base: -1,   vmode: 2, rvmode: 2, exp_out: 128, exp_span: -1};
    vecs[5] = '{len: 63,  base: -1,   vmode: 2, rvmode: 2, exp_out: 64,  exp_span: -1};
    vecs[6] = '{len: 200, base: -1,   vmode: 2, rvmode: 2, exp_out: 256, exp_span: -1};

    reset = 1'b1; valid_i = 1'b0; last_i = 1'b0; ready_v_i = 1'b0; data_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_data_v", 64'(data_v_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_idx", 64'(data_idx_o), 64'd0);
    chk("rst_first", 64'(block_first_o), 64'd0);
    chk("rst_last", 64'(block_last_o), 64'd0);
    chk("rst_ll", ll_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    mon_en = 1'b1;

    // Table-driven messages.
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < vecs[t].len; i++)
        msg[i] = (vecs[t].base < 0) ? 8'($urandom) : 8'(vecs[t].base + i);
      send(vecs[t].len, vecs[t].vmode, vecs[t].rvmode, 1'b0);
      wait_done();
      chk($sformatf("tbl%0d_outcnt", t), 64'(got.size()), 64'(vecs[t].exp_out));
      check_msg($sformatf("tbl%0d", t), vecs[t].len, vecs[t].exp_span);
    end

    // 65-byte message with the core holding off for 5 cycles after block 0.
    for (int i = 0; i < 65; i++) msg[i] = 8'($urandom);
    send(65, 0, 0, 1'b1);
    wait_done();
    check_msg("stall65", 65, 63);

    // Reset while padding at idx 20, then a clean 3-byte message.
    for (int i = 0; i < 3; i++) msg[i] = 8'(8'h11 + i);
    send(3, 0, 0, 1'b0);
    begin
      int g = 0;
      @(negedge clk);
      valid_i = 1'b0; last_i = 1'b0;
      while (!(data_v_o && data_idx_o == 6'd20) && g < 100) begin
        @(negedge clk);
        g++;
      end
      chk("pad_reach_idx20", 64'(data_idx_o), 64'd20);
    end
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_data_v", 64'(data_v_o), 64'd0);
    chk("abort_idx", 64'(data_idx_o), 64'd0);
    chk("abort_flags", 64'({block_first_o, block_last_o}), 64'd0);
    chk("abort_ll", ll_o, 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_quiet", 64'(data_v_o), 64'd0);
    got.delete(); gcyc.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) msg[i] = 8'(8'h61 + i);
    send(3, 0, 0, 1'b0);
    wait_done();
    check_msg("after_abort", 3, 63);

    // IDLE with the core not ready: no transfer until ready_v_i rises.
    msg[0] = 8'h55;
    @(negedge clk);
    valid_i = 1'b1; data_i = 8'h55; last_i = 1'b1; ready_v_i = 1'b0;
    #1;
    chk("idle_hold_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    #1;
    chk("idle_hold_no_out", 64'(data_v_o), 64'd0);
    chk("idle_hold_ll", ll_o, 64'(last_len));
    chk("idle_hold_busy", 64'(busy_o), 64'd0);
    ready_v_i = 1'b1;
    #1;
    chk("idle_rise_ready", 64'(ready_o), 64'd1);
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b0;
    #1;
    chk("one_byte_out", 64'({data_v_o, data_o, data_idx_o, block_first_o, block_last_o}),
        64'({1'b1, 8'h55, 6'd0, 1'b1, 1'b1}));
    chk("one_byte_ll", ll_o, 64'd1);
    chk("one_byte_pad_busy", 64'(busy_o), 64'd1);
    wait_done();
    check_msg("one_byte", 1, 63);

    // Random messages checked against the block-level model.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 200);
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      send(n, 2, 2, 1'b0);
      wait_done();
      check_msg($sformatf("rand%0d", r), n, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
